// File: rtl/note_stream_controller.sv
// Note stream controller: answers codec frames with note-player sample
// requests, forwards samples to dynamics and times the note length.
module note_stream_controller #(
  parameter int FRAMES_PER_UNIT = 1000,
  parameter int TIMEOUT         = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               note_valid,
  input  logic [5:0]         note_duration,
  output logic               note_ready,
  input  logic               new_frame,
  output logic               generate_next_sample,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_ready,
  output logic signed [15:0] sample_out,
  output logic               new_sample_ready,
  output logic               done_with_note,
  output logic               underrun,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    WAIT
  } state_t;

  state_t             state_q;
  logic [5:0]         dur_q;
  logic [15:0]        frame_q;
  logic [5:0]         unit_q;
  logic [15:0]        wait_q;
  logic               ready_q;
  logic               gen_q;
  logic signed [15:0] smp_q;
  logic               nsr_q;
  logic               done_q;
  logic               under_q;
  logic               over_q;

  logic        frame_wrap;
  logic [15:0] frame_d;
  logic [5:0]  unit_d;
  logic        last_frame;
  logic        timeout;

  always_comb begin
    frame_wrap = (frame_q == 16'(FRAMES_PER_UNIT - 1));
    frame_d    = frame_wrap ? 16'd0 : frame_q + 16'd1;
    unit_d     = frame_wrap ? unit_q + 6'd1 : unit_q;
    last_frame = (unit_d == dur_q);
    timeout    = (wait_q == 16'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dur_q   <= '0;
      frame_q <= '0;
      unit_q  <= '0;
      wait_q  <= '0;
      ready_q <= 1'b1;
      gen_q   <= 1'b0;
      smp_q   <= '0;
      nsr_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      gen_q   <= 1'b0;
      nsr_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // note_ready lags IDLE entry by one cycle after a note ends
          ready_q <= 1'b1;
          if (note_valid && ready_q) begin
            dur_q   <= note_duration;
            frame_q <= '0;
            unit_q  <= '0;
            if (note_duration == 6'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= PLAY;
              ready_q <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (new_frame && play) begin
            gen_q   <= 1'b1;
            wait_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wait_q <= wait_q + 16'd1;
          if (new_frame) over_q <= 1'b1;
          if (sample_in_ready || timeout) begin
            smp_q   <= sample_in_ready ? sample_in : 16'sd0;
            nsr_q   <= 1'b1;
            under_q <= !sample_in_ready;
            frame_q <= frame_d;
            unit_q  <= unit_d;
            if (last_frame) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= PLAY;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_ready           = ready_q;
  assign generate_next_sample = gen_q;
  assign sample_out           = smp_q;
  assign new_sample_ready     = nsr_q;
  assign done_with_note       = done_q;
  assign underrun             = under_q;
  assign overrun              = over_q;

endmodule

// File: tb/tb_note_stream_controller.sv
// Scoreboard bench for note_stream_controller (FRAMES_PER_UNIT=4,
// TIMEOUT=8) with a behavioural note-player model.
module tb_note_stream_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b1;
  logic        note_valid = 1'b0;
  logic [5:0]  note_duration = '0;
  logic        note_ready;
  logic        new_frame = 1'b0;
  logic        generate_next_sample;
  logic [15:0] sample_in = '0;
  logic        sample_in_ready = 1'b0;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic        done_with_note;
  logic        underrun;
  logic        overrun;

  note_stream_controller #(
    .FRAMES_PER_UNIT(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .note_valid(note_valid),
    .note_duration(note_duration),
    .note_ready(note_ready),
    .new_frame(new_frame),
    .generate_next_sample(generate_next_sample),
    .sample_in(sample_in),
    .sample_in_ready(sample_in_ready),
    .sample_out(sample_out),
    .new_sample_ready(new_sample_ready),
    .done_with_note(done_with_note),
    .underrun(underrun),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int gen_cnt, nsr_cnt, done_cnt, done_co, under_cnt, over_cnt;
  int last_gen_cyc, done_cyc, rise_cyc, under_dly;
  logic nr_prev = 1'b1;

  logic [15:0] smp_val = 16'd10400;
  int resp_left = -1;
  bit push_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    gen_cnt = 0; nsr_cnt = 0; done_cnt = 0; done_co = 0;
    under_cnt = 0; over_cnt = 0; under_dly = -1;
    done_cyc = -1; rise_cyc = -1;
  endtask

  // note-player model: answers 2 clk after each request
  initial begin
    forever begin
      @(negedge clk);
      if (generate_next_sample) begin
        if (resp_left != 0) begin
          if (resp_left > 0) resp_left--;
          @(posedge clk); #1;
          @(posedge clk); #1;
          sample_in = smp_val;
          sample_in_ready = 1'b1;
          exp_q.push_back('{s: smp_val, u: 1'b0});
          @(posedge clk); #1;
          sample_in_ready = 1'b0;
          sample_in = 16'h5A5A;
        end else if (push_timeout) begin
          exp_q.push_back('{s: 16'd0, u: 1'b1});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (generate_next_sample) begin
      gen_cnt++;
      last_gen_cyc = cyc;
    end
    if (new_sample_ready) begin
      nsr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: sample_out=%h with nothing expected",
                 sample_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (sample_out !== e.s || underrun !== e.u) begin
          failures++;
          $display("FAIL sb_sample: got %h/u%b expected %h/u%b",
                   sample_out, underrun, e.s, e.u);
        end
      end
    end
    if (done_with_note) begin
      done_cnt++;
      done_cyc = cyc;
      if (new_sample_ready) done_co++;
    end
    if (underrun) begin
      under_cnt++;
      under_dly = cyc - last_gen_cyc;
    end
    if (overrun) over_cnt++;
    if (note_ready && !nr_prev) rise_cyc = cyc;
    nr_prev = note_ready;
  end

  task automatic start_note(input logic [5:0] d);
    int n = 0;
    while (!note_ready && n < 100) begin
      tick();
      n++;
    end
    if (!note_ready) begin
      checks++;
      failures++;
      $display("FAIL note_ready_wait: note_ready=%b expected 1", note_ready);
    end
    note_valid = 1'b1;
    note_duration = d;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    repeat (19) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (note_ready !== 1'b1 || sample_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: ready=%b out=%h expected 1/0000",
               note_ready, sample_out);
    end
    checks++;
    if ({generate_next_sample, new_sample_ready, done_with_note,
         underrun, overrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: %b expected 00000",
               {generate_next_sample, new_sample_ready, done_with_note,
                underrun, overrun});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_counts();
    smp_val = 16'd10400;
    resp_left = -1;
    start_note(6'd3);
    repeat (12) frame();
    checks++;
    if (gen_cnt != 12 || nsr_cnt != 12) begin
      failures++;
      $display("FAIL basic_counts: gen=%0d nsr=%0d expected 12/12",
               gen_cnt, nsr_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_co != 1) begin
      failures++;
      $display("FAIL basic_done: done=%0d coinc=%0d expected 1/1",
               done_cnt, done_co);
    end
    checks++;
    if (rise_cyc != done_cyc + 1) begin
      failures++;
      $display("FAIL basic_ready_rise: at %0d expected %0d",
               rise_cyc, done_cyc + 1);
    end
  endtask

  task automatic test_negative();
    clear_counts();
    smp_val = 16'hD760;
    start_note(6'd1);
    repeat (4) frame();
    checks++;
    if (nsr_cnt != 4 || done_cnt != 1 || done_co != 1) begin
      failures++;
      $display("FAIL neg_counts: nsr=%0d done=%0d coinc=%0d expected 4/1/1",
               nsr_cnt, done_cnt, done_co);
    end
    checks++;
    if (sample_out !== 16'hD760) begin
      failures++;
      $display("FAIL neg_hold: sample_out=%h expected d760", sample_out);
    end
  endtask

  task automatic test_overrun();
    clear_counts();
    smp_val = 16'd10400;
    start_note(6'd1);
    frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    repeat (17) tick();
    repeat (2) frame();
    checks++;
    if (over_cnt != 1) begin
      failures++;
      $display("FAIL overrun_pulse: cycles=%0d expected 1", over_cnt);
    end
    checks++;
    if (gen_cnt != 4 || nsr_cnt != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL overrun_counts: gen=%0d nsr=%0d done=%0d expected 4/4/1",
               gen_cnt, nsr_cnt, done_cnt);
    end
  endtask

  task automatic test_pause();
    clear_counts();
    start_note(6'd1);
    repeat (2) frame();
    play = 1'b0;
    repeat (5) frame();
    checks++;
    if (gen_cnt != 2 || done_cnt != 0 || note_ready !== 1'b0) begin
      failures++;
      $display("FAIL pause_hold: gen=%0d done=%0d ready=%b expected 2/0/0",
               gen_cnt, done_cnt, note_ready);
    end
    play = 1'b1;
    repeat (2) frame();
    checks++;
    if (gen_cnt != 4 || nsr_cnt != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL pause_resume: gen=%0d nsr=%0d done=%0d expected 4/4/1",
               gen_cnt, nsr_cnt, done_cnt);
    end
  endtask

  task automatic test_zero();
    clear_counts();
    start_note(6'd0);
    checks++;
    if (done_with_note !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: done=%b expected 1", done_with_note);
    end
    frame();
    checks++;
    if (done_cnt != 1 || gen_cnt != 0 || note_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_counts: done=%0d gen=%0d ready=%b expected 1/0/1",
               done_cnt, gen_cnt, note_ready);
    end
  endtask

  task automatic test_reset_wait();
    clear_counts();
    resp_left = 0;
    push_timeout = 1'b0;
    start_note(6'd2);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (note_ready !== 1'b1 || sample_out !== 16'd0) begin
      failures++;
      $display("FAIL rst_wait_state: ready=%b out=%h expected 1/0000",
               note_ready, sample_out);
    end
    repeat (20) tick();
    checks++;
    if (done_cnt != 0 || nsr_cnt != 0) begin
      failures++;
      $display("FAIL rst_wait_done: done=%0d nsr=%0d expected 0/0",
               done_cnt, nsr_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    smp_val = 16'd10400;
    resp_left = 2;
    push_timeout = 1'b1;
    start_note(6'd1);
    repeat (3) frame();
    checks++;
    if (under_dly != 8) begin
      failures++;
      $display("FAIL underrun_delay: %0d clk expected 8", under_dly);
    end
    frame();
    checks++;
    if (under_cnt != 2 || nsr_cnt != 4 || done_cnt != 1 || done_co != 1) begin
      failures++;
      $display("FAIL timeout_counts: und=%0d nsr=%0d done=%0d co=%0d exp 2/4/1/1",
               under_cnt, nsr_cnt, done_cnt, done_co);
    end
    resp_left = -1;
    push_timeout = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overrun();
    test_pause();
    test_zero();
    test_reset_wait();
    test_timeout();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_stream_controller.md
Name: note_stream_controller

Overview:
- Initiator side of the sample interface that the dynamics block consumes.
- Accepts one note duration at a time and answers each codec new_frame by requesting a sample from the note player with generate_next_sample.
- Captures the returned sample and forwards it to the dynamics stage. Counts frames against the note duration and pulses done_with_note when the note expires.
- Sits between the song sequencer/codec frame tick and the note_player/dynamics chain.

Parameters:
- FRAMES_PER_UNIT, 1000, new_frame pulses per duration unit (1/48 s at 48 kHz; duration 3 = 1/16 s).
- TIMEOUT, 64, clk cycles to wait for sample_in_ready before declaring an underrun.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  level; 0 pauses playback (frames are ignored, counters hold)
- note_valid  in  1  a new note is offered
- note_duration  in  6  duration in units; sampled when note_valid & note_ready
- note_ready  out  1  controller is idle and accepts a note
- new_frame  in  1  one-cycle pulse from the codec requesting a sample
- generate_next_sample  out  1  one-cycle request to the note player
- sample_in  in  16  signed two's-complement sample from the note player
- sample_in_ready  in  1  one-cycle pulse; sample_in is valid
- sample_out  out  16  signed sample forwarded to dynamics (sample_start)
- new_sample_ready  out  1  one-cycle pulse; sample_out updated this cycle
- done_with_note  out  1  one-cycle pulse at the end of the note
- underrun  out  1  one-cycle pulse when a sample request timed out
- overrun  out  1  one-cycle pulse when new_frame arrived while a request was outstanding

Behaviour:

Reset:
- State goes to IDLE; all counters go to 0.
- sample_out = 0; note_ready = 1.
- generate_next_sample, new_sample_ready, done_with_note, underrun and overrun are all 0.
- Reset asserted mid-note aborts the note. No done_with_note pulse is issued.

States: IDLE, PLAY, WAIT.

IDLE:
- note_ready = 1.
- On note_valid, latch note_duration and clear frame_cnt (16 bit) and unit_cnt (6 bit).
- If the latched duration is 0: pulse done_with_note on the next cycle and stay in IDLE.
- Otherwise go to PLAY.
- new_frame is ignored in IDLE; sample_out holds.

PLAY:
- note_ready = 0.
- On new_frame with play = 1: register generate_next_sample high for exactly the next cycle, clear wait_cnt, go to WAIT.
- new_frame with play = 0 is dropped. No request is made and counters hold.

WAIT:
- sample_in_ready is honoured only in WAIT, so the earliest acceptance is the cycle after generate_next_sample is high.
- Its effect is registered: on the next cycle, sample_out = sample_in and new_sample_ready = 1 for one cycle. Latency is 1 clk from sample_in_ready.
- wait_cnt increments every cycle. When wait_cnt reaches TIMEOUT-1 without sample_in_ready: sample_out = 0, new_sample_ready = 1, underrun = 1, each for one cycle. The frame is still counted.
- new_frame in WAIT pulses overrun and is otherwise dropped. It does not queue a request.
- If sample_in_ready and the timeout occur in the same cycle, the sample wins and there is no underrun.

Frame accounting (on each completed frame, whether sample or timeout):
- If frame_cnt == FRAMES_PER_UNIT-1: frame_cnt goes to 0 and unit_cnt increments.
- Otherwise frame_cnt increments.
- If the incremented unit_cnt equals the duration: done_with_note pulses in the same cycle as the final new_sample_ready, and the state goes to IDLE (note_ready = 1 on the following cycle).
- Otherwise return to PLAY.

Other rules:
- note_valid outside IDLE is ignored.
- sample_in passes through unmodified (sign preserved, no arithmetic).
- Maximum note length is 63 × FRAMES_PER_UNIT frames. frame_cnt must not wrap before FRAMES_PER_UNIT-1.
- The sample_in_ready pulse must be a single cycle. A stray sample_in_ready in IDLE or PLAY is ignored.

Test Plan:
- FRAMES_PER_UNIT=4, duration 3, play=1, new_frame every 20 clk, note player responds 2 clk after each request with sample 10400:
  - exactly 12 generate_next_sample pulses;
  - 12 new_sample_ready pulses with sample_out = 10400;
  - done_with_note coincides with the 12th new_sample_ready;
  - note_ready rises 1 clk later.
- Negative sample 16'd0-16'd10400 (0xD760), duration 1, FRAMES_PER_UNIT=4:
  - sample_out = 0xD760 on every valid;
  - 4 frames, then done_with_note.
- TIMEOUT=8, note player never responds after the 2nd request:
  - underrun pulses 8 clk after that generate_next_sample;
  - sample_out = 0 with new_sample_ready;
  - the frame is counted, so the note ends after the same total frame count.
- new_frame issued 1 clk after generate_next_sample:
  - overrun = 1 for one cycle;
  - no second request;
  - frame count unaffected.
- play=0 for 5 new_frame pulses mid-note:
  - no generate_next_sample;
  - counters hold;
  - resuming play completes the remaining frames exactly.
- Duration 0 offered: done_with_note 1 clk after acceptance, no requests.
- reset asserted in WAIT:
  - next cycle IDLE, note_ready = 1, sample_out = 0;
  - no done_with_note.
